galois_lfsr_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_period_tracker.sv | 41 ++++
 rtl/galois_lfsr_gen.sv | 76 +++++++
 tb/tb_galois_lfsr_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared Galois LFSR definitions: default tap masks and the generic next-state function.
package lfsr_pkg;

  localparam logic [4:0]  TAPS_5  = 5'b00100;
  localparam logic [7:0]  TAPS_8  = 8'b00011100;
  localparam logic [15:0] TAPS_16 = 16'b0110100000000000;
  localparam logic [31:0] TAPS_32 = 32'h00400007;

  // Operands are zero-extended to 32 bits; only the low 'width' bits of the result are meaningful.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input int width);
    logic [31:0] mask;
    logic [31:0] msb_bit;
    logic [31:0] n;
    logic        msb;
    mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    msb_bit = 32'd1 << (width - 1);
    msb     = |(s & msb_bit);
    n       = (s << 1) & mask;
    if (msb) n = n ^ (taps & mask & ~32'd1) ^ 32'd1;
    return n;
  endfunction

endpackage

// File: rtl/lfsr_period_tracker.sv
// Holds the last loaded seed, counts steps since load/reset/wrap and flags a return to the seed.
module lfsr_period_tracker #(
  parameter int                 WIDTH    = 5,
  parameter int                 CNT_W    = 32,
  parameter logic [WIDTH-1:0]   RST_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_seed,
  input  logic [WIDTH-1:0] new_seed,
  input  logic             step,
  input  logic [WIDTH-1:0] nxt,
  output logic [CNT_W-1:0] steps,
  output logic             wrap
);

  logic [WIDTH-1:0] seed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= RST_SEED;
      steps  <= '0;
      wrap   <= 1'b0;
    end else if (set_seed) begin
      seed_q <= new_seed;
      steps  <= '0;
      wrap   <= 1'b0;
    end else if (step) begin
      if (nxt == seed_q) begin
        wrap  <= 1'b1;
        steps <= '0;
      end else begin
        wrap  <= 1'b0;
        steps <= steps + CNT_W'(1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/galois_lfsr_gen.sv
// Parametrised internal-XOR LFSR with runtime seed load, lockup recovery and period detection.
module galois_lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS_5),
  parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1),
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             fb,
  output logic             wrap,
  output logic             lockup,
  output logic [CNT_W-1:0] steps
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("galois_lfsr_gen: WIDTH must be in 2..32");
  end
  if (RST_SEED == '0) begin : g_bad_seed
    $error("galois_lfsr_gen: RST_SEED must be non-zero");
  end

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] new_seed;
  logic             is_zero;
  logic             seed_zero;
  logic             set_seed;
  logic             step;

  assign nxt       = WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));
  assign is_zero   = (state == '0);
  assign seed_zero = (seed_in == '0);
  // A zero seed is never allowed into the register; it is treated like a lockup.
  assign set_seed  = load | is_zero;
  assign new_seed  = (load && !seed_zero) ? seed_in : RST_SEED;
  assign step      = !load && !is_zero && en;
  assign fb        = state[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST_SEED;
      lockup <= 1'b0;
    end else if (load) begin
      state  <= new_seed;
      lockup <= seed_zero;
    end else if (is_zero) begin
      state  <= RST_SEED;
      lockup <= 1'b1;
    end else begin
      if (en) state <= nxt;
      lockup <= 1'b0;
    end
  end

  lfsr_period_tracker #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .RST_SEED (RST_SEED)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_seed (set_seed),
    .new_seed (new_seed),
    .step     (step),
    .nxt      (nxt),
    .steps    (steps),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Bench for galois_lfsr_gen: a 5-bit default instance and an 8-bit instance checked against a polynomial model.
module tb_galois_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [4:0]  seed_a = '0;
  logic [7:0]  seed_b = '0;
  logic [4:0]  state_a;
  logic [7:0]  state_b;
  logic        fb_a, fb_b, wrap_a, wrap_b, lockup_a, lockup_b;
  logic [31:0] steps_a, steps_b;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  galois_lfsr_gen u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_a),
    .state(state_a), .fb(fb_a), .wrap(wrap_a), .lockup(lockup_a), .steps(steps_a)
  );

  galois_lfsr_gen #(
    .WIDTH(8), .TAPS(lfsr_pkg::TAPS_8), .RST_SEED(8'h01), .CNT_W(32)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_b),
    .state(state_b), .fb(fb_b), .wrap(wrap_b), .lockup(lockup_b), .steps(steps_b)
  );

  always #5 clk = ~clk;

  // Model: the state is a polynomial over GF(2); a step multiplies it by x modulo the generator.
  int wid[2]  = '{5, 8};
  int poly[2] = '{32'h25, 32'h11D};
  int m_st[2], m_seed[2], m_steps[2];
  bit m_wrap[2], m_lock[2];

  function automatic int mulx(input int s, input int k);
    int r;
    r = s << 1;
    if (((r >> wid[k]) & 1) != 0) r = r ^ poly[k];
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 1; m_seed[k] = 1; m_steps[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
    end
  endtask

  task automatic modelClock(input bit e, input bit l, input int sa, input int sb);
    int sd;
    for (int k = 0; k < 2; k++) begin
      sd = (k == 0) ? sa : sb;
      if (l) begin
        if (sd == 0) begin m_st[k] = 1; m_seed[k] = 1; m_lock[k] = 1; end
        else begin m_st[k] = sd; m_seed[k] = sd; m_lock[k] = 0; end
        m_steps[k] = 0; m_wrap[k] = 0;
      end else if (m_st[k] == 0) begin
        m_st[k] = 1; m_seed[k] = 1; m_steps[k] = 0; m_lock[k] = 1; m_wrap[k] = 0;
      end else if (e) begin
        m_st[k] = mulx(m_st[k], k);
        m_lock[k] = 0;
        if (m_st[k] == m_seed[k]) begin m_wrap[k] = 1; m_steps[k] = 0; end
        else begin m_wrap[k] = 0; m_steps[k] = m_steps[k] + 1; end
      end else begin
        m_wrap[k] = 0; m_lock[k] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit l, input logic [4:0] sa, input logic [7:0] sb);
    en = e; load = l; seed_a = sa; seed_b = sb;
    @(posedge clk);
    modelClock(e, l, int'(sa), int'(sb));
    @(negedge clk);
  endtask

  task automatic doReset();
    chk_on = 1'b0;
    en = 1'b0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
  endtask

  // Every cycle the model and both instances must agree on all outputs.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("a_state",  32'(state_a),  32'(m_st[0]));
      checkOutput("a_fb",     32'(fb_a),     32'((m_st[0] >> 4) & 1));
      checkOutput("a_wrap",   32'(wrap_a),   32'(m_wrap[0]));
      checkOutput("a_lockup", 32'(lockup_a), 32'(m_lock[0]));
      checkOutput("a_steps",  steps_a,       32'(m_steps[0]));
      checkOutput("b_state",  32'(state_b),  32'(m_st[1]));
      checkOutput("b_fb",     32'(fb_b),     32'((m_st[1] >> 7) & 1));
      checkOutput("b_wrap",   32'(wrap_b),   32'(m_wrap[1]));
      checkOutput("b_lockup", 32'(lockup_b), 32'(m_lock[1]));
      checkOutput("b_steps",  steps_b,       32'(m_steps[1]));
    end
  end

  int exp6[6] = '{1, 2, 4, 8, 16, 5};
  bit seen[32];
  int distinct, max_steps, wrap_cnt;

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset values and the first few states of x^5+x^2+1
    checkOutput("reset_state", 32'(state_a), 32'h01);
    checkOutput("reset_steps", steps_a, 32'd0);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
      checkOutput("seq6_state", 32'(state_a), 32'(exp6[i]));
      checkOutput("seq6_steps", steps_a, 32'(i));
    end

    // Full period from reset
    doReset();
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0; max_steps = 0;
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
      if (!seen[state_a]) distinct++;
      seen[state_a] = 1'b1;
      if (i < 31 && int'(steps_a) > max_steps) max_steps = int'(steps_a);
    end
    checkOutput("period_distinct", 32'(distinct), 32'd31);
    checkOutput("period_max_steps", 32'(max_steps), 32'd30);
    checkOutput("period_wrap", 32'(wrap_a), 32'd1);
    checkOutput("period_state", 32'(state_a), 32'h01);
    checkOutput("period_steps", steps_a, 32'd0);

    // Runtime seed and wrap back to it
    applyStimulus(1'b0, 1'b1, 5'b10110, 8'h5A);
    checkOutput("seed_state", 32'(state_a), 32'h16);
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    checkOutput("seed_step1", 32'(state_a), 32'h09);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    checkOutput("seed_wrap", 32'(wrap_a), 32'd1);
    checkOutput("seed_wrap_state", 32'(state_a), 32'h16);

    // Zero seed and forced zero state both recover to the reset seed
    applyStimulus(1'b1, 1'b1, 5'd0, 8'd0);
    checkOutput("zero_load_state", 32'(state_a), 32'h01);
    checkOutput("zero_load_lockup", 32'(lockup_a), 32'd1);
    checkOutput("zero_load_steps", steps_a, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    checkOutput("zero_load_pulse", 32'(lockup_a), 32'd0);
    #2 force u_a.state = 5'd0;
    #1 release u_a.state;
    m_st[0] = 0;
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    checkOutput("force_state", 32'(state_a), 32'h01);
    checkOutput("force_lockup", 32'(lockup_a), 32'd1);
    checkOutput("force_steps", steps_a, 32'd0);

    // Load beats enable, then everything holds while idle
    applyStimulus(1'b1, 1'b1, 5'b01111, 8'hF0);
    checkOutput("load_wins_state", 32'(state_a), 32'h0F);
    checkOutput("load_wins_steps", steps_a, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 5'b10101, 8'h33);
    checkOutput("idle_state", 32'(state_a), 32'h0F);
    checkOutput("idle_steps", steps_a, 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_state", 32'(state_a), 32'h01);
    checkOutput("async_steps", steps_a, 32'd0);
    checkOutput("async_state_b", 32'(state_b), 32'h01);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    checkOutput("async_first_step", 32'(state_a), 32'h02);

    // 8-bit instance: one wrap per 255 steps
    doReset();
    wrap_cnt = 0; max_steps = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
      if (wrap_b) wrap_cnt++;
      if (int'(steps_b) > max_steps) max_steps = int'(steps_b);
    end
    checkOutput("w8_wrap_count", 32'(wrap_cnt), 32'd1);
    checkOutput("w8_wrap_last", 32'(wrap_b), 32'd1);
    checkOutput("w8_state", 32'(state_b), 32'h01);
    checkOutput("w8_max_steps", 32'(max_steps), 32'd254);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
